// File: rtl/btn_tx_sched.sv
// Button-press scheduler: debouncer tick, edge detect, per-button pending queue
// and round-robin grants to the UART transmitter with an acknowledge timeout.
module btn_tx_sched #(
  parameter int         TICK_DIV  = 50000,
  parameter logic [7:0] CODE_BASE = 8'h30,
  parameter int         ACK_TO    = 16
) (
  input  logic       cclk,
  input  logic       clr_n,
  output logic       db_tick,
  input  logic [3:0] btn,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [3:0] pending,
  output logic       drop,
  output logic       err,
  output logic [1:0] dbg_state
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ACK_TO + 1);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALIM  = AW'(ACK_TO);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [TW-1:0] tcnt;
  logic [3:0]    btn_q;
  logic [3:0]    rise;
  logic [3:0]    clr_mask;
  logic [1:0]    state;
  logic [1:0]    gnt;
  logic [1:0]    last;
  logic [1:0]    win;
  logic [AW-1:0] acnt;
  logic [AW-1:0] acnt_inc;

  assign dbg_state = state;
  assign acnt_inc  = acnt + 1'b1;

  always_ff @(posedge cclk or negedge clr_n) begin
    if (!clr_n) begin
      tcnt    <= '0;
      db_tick <= 1'b0;
    end else begin
      db_tick <= (tcnt == TLAST);
      tcnt    <= (tcnt == TLAST) ? '0 : tcnt + 1'b1;
    end
  end

  // A set on the same cycle as the grant's clear wins, so that press survives.
  assign rise     = btn & ~btn_q;
  assign clr_mask = (state == S_SEND) ? (4'b0001 << gnt) : 4'b0000;

  always_ff @(posedge cclk or negedge clr_n) begin
    if (!clr_n) begin
      btn_q   <= 4'b0000;
      pending <= 4'b0000;
      drop    <= 1'b0;
    end else begin
      btn_q   <= btn;
      pending <= (pending & ~clr_mask) | rise;
      drop    <= |(rise & pending & ~clr_mask);
    end
  end

  // Round-robin search starting just after the last granted button.
  always_comb begin
    win = last;
    for (int j = 4; j >= 1; j--) begin
      if (pending[last + 2'(j)]) win = last + 2'(j);
    end
  end

  // Handshake: tx_start pulses for exactly one cycle (SEND) with tx_data valid
  // and held until the next start; the transmitter must raise tx_busy within
  // ACK_TO cycles, and no new start is issued until tx_busy has fallen again.
  always_ff @(posedge cclk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      gnt      <= 2'd0;
      last     <= 2'd3;
      acnt     <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      err      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((pending != 4'b0000) && !tx_busy) begin
            gnt      <= win;
            tx_data  <= CODE_BASE + {6'd0, win};
            tx_start <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          last  <= gnt;
          acnt  <= '0;
          state <= S_ACK;
        end
        S_ACK: begin
          if (tx_busy) begin
            state <= S_DRAIN;
          end else if (acnt_inc == ALIM) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            acnt <= acnt_inc;
          end
        end
        default: begin
          if (!tx_busy) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_tx_sched.sv
// Bench for btn_tx_sched: directed scenarios plus random presses and transmitter
// behaviour, checked cycle by cycle against a behavioural model of the scheduler.
module tb_btn_tx_sched;

  localparam int TD  = 4;
  localparam int ATO = 16;

  logic       cclk = 1'b0;
  logic       clr_n = 1'b0;
  logic       db_tick;
  logic [3:0] btn = 4'b0000;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] pending;
  logic       drop;
  logic       err;
  logic [1:0] dbg_state;

  btn_tx_sched #(.TICK_DIV(TD), .CODE_BASE(8'h30), .ACK_TO(ATO)) dut (
    .cclk(cclk), .clr_n(clr_n), .db_tick(db_tick), .btn(btn), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .pending(pending), .drop(drop),
    .err(err), .dbg_state(dbg_state)
  );

  always #5 cclk = ~cclk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int n_drop = 0;
  int n32 = 0;

  // transmitter model controls
  int tx_len = 10;
  int busy_left = 0;
  logic force_busy = 1'b0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_FREE = 0, PH_START = 1, PH_AWAIT = 2, PH_DRAIN = 3;
  int         m_k;
  int         m_phase;
  int         m_g;
  int         m_last;
  int         m_waited;
  logic [3:0] m_prev;
  logic       m_tick, m_start, m_drop, m_err;
  logic [7:0] m_data;
  logic [3:0] m_pending;

  task automatic model_reset();
    m_k = 0; m_phase = PH_FREE; m_g = 0; m_last = 3; m_waited = 0;
    m_prev = 4'b0000; m_tick = 0; m_start = 0; m_drop = 0; m_err = 0;
    m_data = 8'h00; m_pending = 4'b0000;
  endtask

  task automatic model_step(input logic [3:0] b, input logic busy);
    logic [3:0] rise, clr, nxt;
    bit found;
    m_k++;
    m_tick = ((m_k % TD) == 0);
    rise = b & ~m_prev;
    m_prev = b;
    clr = (m_phase == PH_START) ? 4'(1 << m_g) : 4'b0000;
    m_drop = ((rise & m_pending & ~clr) != 4'b0000);
    nxt = (m_pending & ~clr) | rise;
    m_start = 0;
    if (m_phase == PH_FREE) begin
      if (m_pending != 4'b0000 && !busy) begin
        found = 0;
        for (int j = 1; j <= 4; j++) begin
          int idx;
          idx = (m_last + j) % 4;
          if (!found && m_pending[idx]) begin
            found = 1;
            m_g = idx;
          end
        end
        m_data = 8'((48 + m_g) % 256);
        m_start = 1;
        m_phase = PH_START;
      end
    end else if (m_phase == PH_START) begin
      m_last = m_g;
      m_waited = 0;
      m_phase = PH_AWAIT;
    end else if (m_phase == PH_AWAIT) begin
      if (busy) m_phase = PH_DRAIN;
      else begin
        m_waited++;
        if (m_waited >= ATO) begin
          m_err = 1;
          m_phase = PH_FREE;
        end
      end
    end else begin
      if (!busy) m_phase = PH_FREE;
    end
    m_pending = nxt;
  endtask

  initial model_reset();

  // compare process: mid-cycle, inputs and outputs stable
  always @(negedge cclk) begin
    if (!clr_n) model_reset();
    check("db_tick", db_tick, m_tick);
    check("tx_start", tx_start, m_start);
    check("tx_data", tx_data, m_data);
    check("pending", pending, m_pending);
    check("drop", drop, m_drop);
    check("err", err, m_err);
    if (clr_n) begin
      if (tx_start === 1'b1) begin
        if (tx_data == 8'h32) n32++;
        if (exp_q.size() > 0) check("sb_byte", tx_data, exp_q.pop_front());
      end
      if (drop === 1'b1) n_drop++;
      model_step(btn, tx_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge cclk);
    #1;
    if (prev_start && tx_len > 0) busy_left = tx_len;
    tx_busy = force_busy || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    prev_start = tx_start;
  endtask

  task automatic apply_reset();
    clr_n = 1'b0;
    busy_left = 0;
    step();
    step();
    clr_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(m_phase == PH_FREE && !tx_busy && busy_left == 0 && m_pending == 4'b0000) && n < 400) begin
      step();
      n++;
    end
    check("wait_idle", (n < 400), 1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (tx_start !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("wait_start", tx_start, 1);
  endtask

  task automatic wait_q_empty();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      step();
      n++;
    end
    check("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and tick cadence
    step();
    step();
    clr_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("tick_cadence", db_tick, ((k % 4) == 0));
      check("idle_start", tx_start, 0);
      check("idle_data", tx_data, 8'h00);
      check("idle_pend", pending, 4'b0000);
    end

    // single press latency
    btn = 4'b0001;
    step();
    check("p1_pend", pending, 4'b0001);
    btn = 4'b0000;
    step();
    check("p1_start", tx_start, 1);
    check("p1_data", tx_data, 8'h30);
    step();
    check("p1_clear", pending, 4'b0000);
    wait_idle();

    // all four buttons after reset, then round-robin from last=3
    apply_reset();
    btn = 4'b1111;
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    exp_q.push_back(8'h32); exp_q.push_back(8'h33);
    step();
    btn = 4'b0000;
    wait_q_empty();
    wait_idle();
    btn = 4'b0011;
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    step();
    btn = 4'b0000;
    wait_q_empty();
    wait_idle();

    // double press behind busy, then a press in the SEND cycle
    n_drop = 0;
    n32 = 0;
    force_busy = 1'b1;
    tx_busy = 1'b1;
    step();
    btn = 4'b0100; step();
    btn = 4'b0000; step();
    btn = 4'b0100; step();
    btn = 4'b0000; step(); step(); step();
    check("t4_drop", n_drop, 1);
    check("t4_held", n32, 0);
    force_busy = 1'b0;
    tx_busy = 1'b0;
    step();
    check("t4_start", tx_start, 1);
    check("t4_data", tx_data, 8'h32);
    btn = 4'b0100;
    step();
    check("t4_keep", pending, 4'b0100);
    btn = 4'b0000;
    wait_idle();
    check("t4_n32", n32, 2);
    check("t4_drop2", n_drop, 1);

    // acknowledge timeout
    tx_len = 0;
    btn = 4'b0001;
    step();
    btn = 4'b0000;
    wait_start();
    for (int k = 1; k <= 17; k++) begin
      step();
      check("t5_err", err, (k == 17));
    end
    tx_len = 10;
    step();
    btn = 4'b0010;
    exp_q.push_back(8'h31);
    step();
    btn = 4'b0000;
    wait_q_empty();
    wait_idle();
    check("t5_sticky", err, 1);

    // reset during DRAIN with busy held
    btn = 4'b0001;
    wait_start();
    step();
    step();
    force_busy = 1'b1;
    tx_busy = 1'b1;
    clr_n = 1'b0;
    #1;
    check("t6_tick", db_tick, 0);
    check("t6_start", tx_start, 0);
    check("t6_data", tx_data, 8'h00);
    check("t6_pend", pending, 4'b0000);
    check("t6_drop", drop, 0);
    check("t6_err", err, 0);
    step();
    step();
    busy_left = 0;
    clr_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t6_blocked", tx_start, 0);
    end
    check("t6_queued", pending, 4'b0001);
    force_busy = 1'b0;
    tx_busy = 1'b0;
    wait_start();
    check("t6_data2", tx_data, 8'h30);
    btn = 4'b0000;
    wait_idle();

    // random presses and transmitter behaviour
    for (int i = 0; i < 3000; i++) begin
      if ((i % 40) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        tx_len = (r == 0) ? 0 : (r % 7) + 1;
      end
      if ($urandom_range(0, 3) == 0) btn = 4'($urandom_range(0, 15));
      if (i == 1500) begin
        clr_n = 1'b0;
        busy_left = 0;
        step();
        step();
        clr_n = 1'b1;
      end
      step();
    end
    check("final_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
